lut_scan_reader: RTL

Read-side companion to the 16-entry 1-bit truth-table RAM that the LUT writer fills. On a start pulse the block sweeps every address through a one-cycle-latency read port. It emits the address of each entry holding 1 (each minterm) on a valid/ready stream and keeps a running count of ones. It sits between the truth-table storage and downstream consumers such as minimisation and checking logic.

---
 rtl/lut_scan_reader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/lut_scan_reader.sv
// Sweeps a 1-bit truth-table RAM through a one-cycle-latency read port, streams the
// address of every set entry on a valid/ready interface, and counts the ones found.
module lut_scan_reader #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW-1:0] m_addr,
  output logic [AW:0]   ones_cnt,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAP,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   ones_q, ones_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          busy_q, busy_d;
  logic          rd_en_q, rd_en_d;
  logic          m_valid_q, m_valid_d;
  logic          done_q, done_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ones_d   = ones_q;
    m_addr_d = m_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          idx_d   = '0;
          ones_d  = '0;
        end
      end
      S_REQ: state_d = S_CAP;
      S_CAP: begin
        if (rd_data) begin
          m_addr_d = idx_q;
          state_d  = S_EMIT;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_REQ;
        end
      end
      S_EMIT: begin
        if (m_ready) begin
          ones_d = ones_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with the FSM.
    rd_en_d   = (state_d == S_REQ);
    rd_addr_d = (state_d == S_REQ) ? idx_d : rd_addr_q;
    m_valid_d = (state_d == S_EMIT);
    done_d    = (state_d == S_DONE);
    busy_d    = (state_d == S_REQ) || (state_d == S_CAP) || (state_d == S_EMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      ones_q    <= '0;
      m_addr_q  <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      m_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ones_q    <= ones_d;
      m_addr_q  <= m_addr_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      rd_en_q   <= rd_en_d;
      m_valid_q <= m_valid_d;
      done_q    <= done_d;
    end
  end

  assign busy     = busy_q;
  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign m_valid  = m_valid_q;
  assign m_addr   = m_addr_q;
  assign ones_cnt = ones_q;
  assign done     = done_q;

endmodule
